// File: rtl/dp_stream_reader_if.sv
// Memory read port and output stream of the stream reader, bundled so the
// reader and its memory/consumer attach through one port each.
interface dp_stream_reader_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 8
) ();

  // Memory request side.
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // Stream side.
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // The reader: issues reads, produces the stream.
  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_ack,
    input  mem_rdata,
    output out_data,
    output out_valid,
    input  out_ready
  );

  // Memory plus consumer: answers reads, accepts the stream.
  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_ack,
    output mem_rdata,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/dp_stream_reader.sv
// Reads `count` consecutive words starting at `base_addr` from a simple
// request/acknowledge memory port and forwards them one at a time on a
// valid/ready stream. Only one word is ever in flight: the next read is not
// issued until the previous word has been accepted downstream.
module dp_stream_reader #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [CNT_W-1:0]   count,
  input  logic               abort,
  dp_stream_reader_if.master bus,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                rd_q, rd_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state logic; every output is computed here one cycle ahead so that
  // all outputs leave the block straight from flops.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    rd_d    = rd_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // abort is deliberately not looked at here: start always wins.
        if (start) begin
          if (count != '0) begin
            ptr_d   = base_addr;
            rem_d   = count;
            rd_d    = 1'b1;
            busy_d  = 1'b1;
            state_d = StRead;
          end else begin
            // Empty transfer: report completion without touching memory.
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end

      StRead: begin
        if (abort) begin
          rd_d    = 1'b0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (bus.mem_ack) begin
          data_d  = bus.mem_rdata;
          valid_d = 1'b1;
          rd_d    = 1'b0;
          // Address wraps naturally at the top of the address space.
          ptr_d   = ptr_q + ADDR_W'(1);
          rem_d   = rem_q - CNT_W'(1);
          state_d = StDrain;
        end
      end

      StDrain: begin
        if (abort) begin
          rd_d    = 1'b0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          if (rem_q != '0) begin
            rd_d    = 1'b1;
            state_d = StRead;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end

      StDone: begin
        // Single-cycle completion pulse; abort lands in the same place.
        state_d = StIdle;
      end

      default: begin
        rd_d    = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      rem_q   <= '0;
      rd_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The read pointer doubles as the memory address; it only moves on ack.
  assign bus.mem_addr  = ptr_q;
  assign bus.mem_rd    = rd_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

  // A read request and a pending stream word must never coexist.
  a_one_in_flight: assert property (@(posedge clk) disable iff (!reset)
    !(rd_q && valid_q));

  // Completion is only ever reported while idle-bound, never while busy.
  a_done_not_busy: assert property (@(posedge clk) disable iff (!reset)
    !(done_q && busy_q));

  // An unanswered read keeps its request and address steady.
  a_rd_stable: assert property (@(posedge clk) disable iff (!reset)
    (rd_q && !bus.mem_ack && !abort) |=> (rd_q && $stable(ptr_q)));

endmodule

// File: tb/tb_dp_stream_reader.sv
// Bench for dp_stream_reader: a transfer-level model (words requested,
// words queued, words delivered) predicts every output each cycle; directed
// scenarios pin the model with hand-computed addresses, data and timing.
module tb_dp_stream_reader;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;

  dp_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dp_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .abort     (abort),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: 0 idle, 1 transfer running, 2 completion cycle.
  int            m_st;
  logic [AW-1:0] m_addr;
  int            m_cnt;
  int            m_req;
  int            m_del;
  logic [DW-1:0] q[$];
  logic [AW-1:0] addr_log[$];
  logic [DW-1:0] data_log[$];
  int            done_cnt  = 0;
  int            rd_cycles = 0;
  bit            rand_mode = 1'b0;
  bit            ack_force = 1'b1;
  bit            rdy_force = 1'b1;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st  = 0;
    m_cnt = 0;
    m_req = 0;
    m_del = 0;
    q.delete();
  endtask

  // Runs at the falling edge: outputs and the inputs for the next rising
  // edge are both stable here.
  task automatic compare();
    bit exp_rd;
    bit exp_ov;
    if (!reset) begin
      check("rst_mem_rd", 32'(bus.mem_rd), 32'h0);
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      model_reset();
    end else begin
      exp_rd = (m_st == 1) && (q.size() == 0) && (m_req < m_cnt);
      exp_ov = (m_st == 1) && (q.size() != 0);
      check("busy", 32'(busy), 32'(m_st == 1));
      check("done", 32'(done), 32'(m_st == 2));
      check("mem_rd", 32'(bus.mem_rd), 32'(exp_rd));
      check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      if (exp_rd) check("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
      if (exp_ov) check("out_data", 32'(bus.out_data), 32'(q[0]));
      if (bus.mem_rd) rd_cycles++;
      if (done) done_cnt++;

      // Effect of the coming rising edge.
      case (m_st)
        0: begin
          if (start) begin
            m_addr = base_addr;
            m_cnt  = int'(count);
            m_req  = 0;
            m_del  = 0;
            q.delete();
            m_st   = (count == '0) ? 2 : 1;
          end
        end
        1: begin
          if (abort) begin
            m_st = 0;
            q.delete();
          end else if (exp_rd && bus.mem_ack) begin
            q.push_back(bus.mem_rdata);
            addr_log.push_back(m_addr);
            m_addr = m_addr + 1'b1;
            m_req++;
          end else if (exp_ov && bus.out_ready) begin
            data_log.push_back(q.pop_front());
            m_del++;
            if (m_del == m_cnt) m_st = 2;
          end
        end
        default: m_st = 0;
      endcase
    end
  endtask

  // Memory and consumer behaviour for the next cycle.
  task automatic respond();
    if (rand_mode) begin
      bus.mem_ack   = ($urandom_range(0, 2) != 0);
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = DW'($urandom);
    end else begin
      bus.mem_ack   = ack_force;
      bus.out_ready = rdy_force;
      bus.mem_rdata = bus.mem_rd ? memf(bus.mem_addr) : ~memf(bus.mem_addr);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    respond();
  endtask

  task automatic start_xfer(input logic [AW-1:0] b, input int c);
    start     = 1'b1;
    base_addr = b;
    count     = CW'(c);
    cycle();
    start     = 1'b0;
    base_addr = AW'($urandom);
    count     = CW'($urandom);
  endtask

  task automatic run_until_done(input int budget, output int n);
    int d0;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      cycle();
      n++;
    end
    check("done_within_budget", 32'(done_cnt != d0), 32'h1);
  endtask

  initial begin
    int a0, b0, d0, r0, n;
    bit found;
    logic [DW-1:0] held;

    reset = 1'b0; start = 1'b0; abort = 1'b0;
    base_addr = '0; count = '0;
    bus.mem_ack = 1'b0; bus.out_ready = 1'b0; bus.mem_rdata = '0;
    model_reset();

    // Reset state before any clock edge.
    #1;
    check("r_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("r_mem_rd", 32'(bus.mem_rd), 32'h0);
    check("r_out_data", 32'(bus.out_data), 32'h0);
    check("r_out_valid", 32'(bus.out_valid), 32'h0);
    check("r_busy", 32'(busy), 32'h0);
    check("r_done", 32'(done), 32'h0);
    cycle();
    cycle();
    reset = 1'b1;
    cycle();

    // Plain transfer of three words, everything ready.
    a0 = addr_log.size(); b0 = data_log.size(); d0 = done_cnt; r0 = rd_cycles;
    start_xfer(20'h00100, 3);
    run_until_done(40, n);
    check("t1_latency", 32'(n), 32'd7);  // 2 cycles per word, then the done cycle
    check("t1_addr0", 32'(addr_log[a0]), 32'h00100);
    check("t1_addr1", 32'(addr_log[a0 + 1]), 32'h00101);
    check("t1_addr2", 32'(addr_log[a0 + 2]), 32'h00102);
    check("t1_beats", 32'(data_log.size() - b0), 32'd3);
    check("t1_data0", 32'(data_log[b0]), 32'hA5);
    check("t1_data1", 32'(data_log[b0 + 1]), 32'hA4);
    check("t1_data2", 32'(data_log[b0 + 2]), 32'hA7);
    check("t1_rd_cycles", 32'(rd_cycles - r0), 32'd3);
    cycle();
    check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t1_busy_after", 32'(busy), 32'h0);
    check("t1_done_after", 32'(done), 32'h0);

    // Address wrap at the top of the space.
    a0 = addr_log.size(); b0 = data_log.size();
    start_xfer(20'hFFFFE, 3);
    run_until_done(40, n);
    check("t2_addr0", 32'(addr_log[a0]), 32'hFFFFE);
    check("t2_addr1", 32'(addr_log[a0 + 1]), 32'hFFFFF);
    check("t2_addr2", 32'(addr_log[a0 + 2]), 32'h00000);
    check("t2_data2", 32'(data_log[b0 + 2]), 32'hA5);
    cycle();

    // Consumer stall of five cycles on the second word.
    b0 = data_log.size(); r0 = rd_cycles;
    start_xfer(20'h00200, 4);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (bus.out_valid && (data_log.size() - b0 == 1)) found = 1'b1;
    end
    check("t3_beat2_seen", 32'(found), 32'h1);
    rdy_force = 1'b0;
    bus.out_ready = 1'b0;
    held = bus.out_data;
    check("t3_held_value", 32'(held), 32'hA4);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t3_stall_data", 32'(bus.out_data), 32'(held));
      check("t3_stall_valid", 32'(bus.out_valid), 32'h1);
      check("t3_stall_rd", 32'(bus.mem_rd), 32'h0);
    end
    rdy_force = 1'b1;
    bus.out_ready = 1'b1;
    run_until_done(40, n);
    check("t3_beats", 32'(data_log.size() - b0), 32'd4);
    check("t3_data0", 32'(data_log[b0]), 32'hA5);
    check("t3_data1", 32'(data_log[b0 + 1]), 32'hA4);
    check("t3_data2", 32'(data_log[b0 + 2]), 32'hA7);
    check("t3_data3", 32'(data_log[b0 + 3]), 32'hA6);
    check("t3_rd_cycles", 32'(rd_cycles - r0), 32'd4);
    cycle();

    // Empty transfer.
    d0 = done_cnt; r0 = rd_cycles;
    start_xfer(20'h00777, 0);
    check("t4_done_next", 32'(done), 32'h1);
    check("t4_busy", 32'(busy), 32'h0);
    check("t4_no_rd", 32'(bus.mem_rd), 32'h0);
    cycle();
    check("t4_done_once", 32'(done), 32'h0);
    cycle();
    check("t4_done_count", 32'(done_cnt - d0), 32'd1);
    check("t4_rd_cycles", 32'(rd_cycles - r0), 32'd0);

    // Abort coinciding with the second memory acknowledge.
    a0 = addr_log.size();
    start_xfer(20'h00300, 4);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (bus.mem_rd && (addr_log.size() - a0 == 1)) found = 1'b1;
    end
    check("t5_beat2_req", 32'(found), 32'h1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    d0 = done_cnt;
    check("t5_rd_off", 32'(bus.mem_rd), 32'h0);
    check("t5_valid_off", 32'(bus.out_valid), 32'h0);
    check("t5_busy_off", 32'(busy), 32'h0);
    check("t5_done_off", 32'(done), 32'h0);
    repeat (5) cycle();
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    a0 = addr_log.size(); b0 = data_log.size();
    start_xfer(20'h00400, 2);
    run_until_done(40, n);
    check("t5_restart_addr0", 32'(addr_log[a0]), 32'h00400);
    check("t5_restart_addr1", 32'(addr_log[a0 + 1]), 32'h00401);
    check("t5_restart_beats", 32'(data_log.size() - b0), 32'd2);
    cycle();

    // Asynchronous reset pulse between clock edges mid-transfer.
    start_xfer(20'h00500, 5);
    repeat (3) cycle();
    #1 reset = 1'b0;
    #1;
    check("t6_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("t6_mem_rd", 32'(bus.mem_rd), 32'h0);
    check("t6_out_data", 32'(bus.out_data), 32'h0);
    check("t6_out_valid", 32'(bus.out_valid), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_done", 32'(done), 32'h0);
    #1 reset = 1'b1;
    model_reset();
    d0 = done_cnt;
    repeat (10) cycle();
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_idle_busy", 32'(busy), 32'h0);

    // Randomised traffic: random starts (also while busy), lengths, aborts,
    // addresses near the wrap point, memory latency and back-pressure.
    rand_mode = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      start     = ($urandom_range(0, 5) == 0);
      base_addr = ($urandom_range(0, 3) == 0) ? AW'(20'hFFFFD + $urandom_range(0, 2))
                                              : AW'($urandom);
      count     = CW'($urandom_range(0, 6));
      abort     = ($urandom_range(0, 40) == 0);
    end
    start = 1'b0;
    abort = 1'b0;
    rand_mode = 1'b0;
    repeat (40) cycle();
    check("rand_completions", 32'(done_cnt - d0 > 20), 32'h1);
    check("rand_idle_at_end", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
